// File: rtl/sflash_pkg.sv
// Shared constants, states and opcode decode for the SPI flash target.
// Opcode subset is read-only; quad output depends on SFLASH_TARGET_QUAD_EN.
package sflash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FREAD = 8'h0B;
    localparam logic [7:0] CMD_DREAD = 8'h3B;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam logic [7:0] CMD_RDID  = 8'h9F;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    localparam int DUMMY_CLKS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } sft_state_t;

    typedef enum logic [1:0] {
        W_SDR,
        W_DUAL,
        W_QUAD
    } width_t;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_ID,
        SRC_ZERO
    } src_t;

    typedef struct packed {
        sft_state_t nxt;
        logic       dummy;
        width_t     width;
        src_t       src;
    } cmd_dec_t;

    function automatic cmd_dec_t decode(input logic [7:0] op,
                                        input logic       quad_en);
        cmd_dec_t d;
        d.nxt   = ST_IGNORE;
        d.dummy = 1'b0;
        d.width = W_SDR;
        d.src   = SRC_ZERO;
        case (op)
            CMD_READ: begin
                d.nxt = ST_ADDR;
                d.src = SRC_MEM;
            end
            CMD_FREAD: begin
                d.nxt   = ST_ADDR;
                d.dummy = 1'b1;
                d.src   = SRC_MEM;
            end
            CMD_DREAD: begin
                d.nxt   = ST_ADDR;
                d.dummy = 1'b1;
                d.width = W_DUAL;
                d.src   = SRC_MEM;
            end
            CMD_QREAD: begin
                if (quad_en) begin
                    d.nxt   = ST_ADDR;
                    d.dummy = 1'b1;
                    d.width = W_QUAD;
                    d.src   = SRC_MEM;
                end
            end
            CMD_RDID: begin
                d.nxt = ST_DATA;
                d.src = SRC_ID;
            end
            CMD_RDSR: begin
                d.nxt = ST_DATA;
                d.src = SRC_ZERO;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sflash_target_if.sv
// Six-wire SPI pins plus the byte-wide memory read port of the target.
// master = controller/memory side, slave = flash target.
interface sflash_target_if;
    import sflash_pkg::*;

    logic        sclk;
    logic        cs_n;
    logic [3:0]  qdi;
    logic [3:0]  qdo;
    logic [3:0]  oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport master (
        output sclk, cs_n, qdi, mem_ack, mem_data,
        input  qdo, oe, mem_addr, mem_rd
    );

    modport slave (
        input  sclk, cs_n, qdi, mem_ack, mem_data,
        output qdo, oe, mem_addr, mem_rd
    );

endinterface

// File: rtl/sflash_target_pin_sync.sv
// Two-flop synchronizer for sclk, cs_n and IO[3:0], with sclk/cs_n edge pulses.
// cs_n resets low so a frame already in progress at reset is never seen to start.
module spi_pin_sync
    import sflash_pkg::*;
(
    input  logic       clk,
    input  logic       arstn,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] qdi,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_rise,
    output logic       cs_fall,
    output logic [3:0] qdi_s
);

    // bit 5 = sclk (idles high), bit 4 = cs_n, bits 3:0 = IO
    localparam logic [5:0] SYNC_RST = 6'b10_0000;

    logic [5:0] s1_q, s1_d;
    logic [5:0] s2_q, s2_d;
    logic [1:0] prev_q, prev_d;

    // Next values of the synchronizer chain and edge-detect history
    always_comb begin
        s1_d   = {sclk, cs_n, qdi};
        s2_d   = s1_q;
        prev_d = s2_q[5:4];
    end

    // Synchronizer and history registers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s1_q   <= SYNC_RST;
            s2_q   <= SYNC_RST;
            prev_q <= SYNC_RST[5:4];
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign sclk_rise = s2_q[5] & ~prev_q[1];
    assign sclk_fall = ~s2_q[5] & prev_q[1];
    assign cs_rise   = s2_q[4] & ~prev_q[0];
    assign cs_fall   = ~s2_q[4] & prev_q[0];
    assign qdi_s     = s2_q[3:0];

endmodule

// File: rtl/sflash_target.sv
// Read-only SPI flash responder: 03/0B/3B/6B/9F/05 over an oversampled bus.
// Define SFLASH_TARGET_QUAD_EN to enable 0x6B and drive IO[3:2].
module sflash_target
    import sflash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID = 24'hC84015
) (
    input  logic            clk,
    input  logic            arstn,
    sflash_target_if.slave  bus,
    output logic            busy,
    output logic            underrun
);

`ifdef SFLASH_TARGET_QUAD_EN
    localparam logic QUAD_EN = 1'b1;
`else
    localparam logic QUAD_EN = 1'b0;
`endif
    localparam logic [3:0] PIN_MASK = QUAD_EN ? 4'hF : 4'h3;

    logic       sclk_rise, sclk_fall;
    logic       cs_rise, cs_fall;
    logic [3:0] qdi_s;

    spi_pin_sync u_sync (
        .clk       (clk),
        .arstn     (arstn),
        .sclk      (bus.sclk),
        .cs_n      (bus.cs_n),
        .qdi       (bus.qdi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .qdi_s     (qdi_s)
    );

    sft_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    width_t      width_q, width_d;
    src_t        src_q, src_d;
    logic        dummy_q, dummy_d;
    logic [1:0]  id_idx_q, id_idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [3:0]  qdo_q, qdo_d;
    logic [3:0]  oe_q, oe_d;
    logic [23:0] fa_q, fa_d;
    logic        rd_q, rd_d;
    logic        pend_q, pend_d;
    logic        stale_q, stale_d;
    logic        want_q, want_d;
    logic        bvld_q, bvld_d;
    logic [7:0]  buf_q, buf_d;
    logic        unr_q, unr_d;

    cmd_dec_t    dec;
    logic [7:0]  nb;
    logic [2:0]  last;

    // Frame FSM, data shifter, prefetch buffer and fetch issue
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        width_d  = width_q;
        src_d    = src_q;
        dummy_d  = dummy_q;
        id_idx_d = id_idx_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        qdo_d    = qdo_q;
        oe_d     = oe_q;
        fa_d     = fa_q;
        rd_d     = 1'b0;
        pend_d   = pend_q;
        stale_d  = stale_q;
        want_d   = want_q;
        bvld_d   = bvld_q;
        buf_d    = buf_q;
        unr_d    = unr_q;
        nb       = 8'h00;
        last     = 3'd7;
        dec      = decode({sr_q[6:0], qdi_s[0]}, QUAD_EN);

        // Address advances the cycle after each issued request
        if (rd_q) begin
            fa_d = fa_q + 24'd1;
        end

        // A return belonging to an aborted frame is dropped
        if (bus.mem_ack) begin
            pend_d = 1'b0;
            if (stale_q) begin
                stale_d = 1'b0;
            end else if (state_q != ST_IDLE) begin
                buf_d  = bus.mem_data;
                bvld_d = 1'b1;
            end
        end

        if (cs_rise) begin
            state_d  = ST_IDLE;
            oe_d     = 4'h0;
            qdo_d    = 4'h0;
            cnt_d    = 5'd0;
            bit_d    = 3'd0;
            id_idx_d = 2'd0;
            bvld_d   = 1'b0;
            want_d   = 1'b0;
            stale_d  = pend_d;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d  = ST_CMD;
                        cnt_d    = 5'd0;
                        bit_d    = 3'd0;
                        id_idx_d = 2'd0;
                        bvld_d   = 1'b0;
                        want_d   = 1'b0;
                        unr_d    = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        sr_d  = {sr_q[22:0], qdi_s[0]};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = 5'd0;
                            state_d = dec.nxt;
                            dummy_d = dec.dummy;
                            width_d = dec.width;
                            src_d   = dec.src;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        sr_d  = {sr_q[22:0], qdi_s[0]};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d   = 5'd0;
                            fa_d    = sr_d;
                            want_d  = 1'b1;
                            state_d = dummy_q ? ST_DUMMY : ST_DATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'(DUMMY_CLKS - 1)) begin
                            cnt_d   = 5'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        if (bit_q == 3'd0) begin
                            unique case (src_q)
                                SRC_ID: begin
                                    case (id_idx_q)
                                        2'd0:    nb = JEDEC_ID[23:16];
                                        2'd1:    nb = JEDEC_ID[15:8];
                                        2'd2:    nb = JEDEC_ID[7:0];
                                        default: nb = 8'h00;
                                    endcase
                                    if (id_idx_q != 2'd3) begin
                                        id_idx_d = id_idx_q + 2'd1;
                                    end
                                end
                                SRC_MEM: begin
                                    want_d = 1'b1;
                                    if (bvld_d) begin
                                        nb     = buf_d;
                                        bvld_d = 1'b0;
                                    end else begin
                                        nb    = 8'hFF;
                                        unr_d = 1'b1;
                                    end
                                end
                                default: nb = 8'h00;
                            endcase
                        end else begin
                            nb = tx_q;
                        end
                        unique case (width_q)
                            W_DUAL: begin
                                qdo_d = {2'b00, nb[7:6]};
                                oe_d  = 4'b0011;
                                tx_d  = {nb[5:0], 2'b00};
                                last  = 3'd3;
                            end
                            W_QUAD: begin
                                qdo_d = nb[7:4];
                                oe_d  = 4'b1111;
                                tx_d  = {nb[3:0], 4'h0};
                                last  = 3'd1;
                            end
                            default: begin
                                qdo_d = {2'b00, nb[7], 1'b0};
                                oe_d  = 4'b0010;
                                tx_d  = {nb[6:0], 1'b0};
                                last  = 3'd7;
                            end
                        endcase
                        bit_d = (bit_q == last) ? 3'd0 : bit_q + 3'd1;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // One request in flight, and only into an empty buffer
        if (want_d && !pend_d && !bvld_d && (state_d != ST_IDLE)) begin
            rd_d   = 1'b1;
            pend_d = 1'b1;
            want_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            sr_q     <= 24'd0;
            width_q  <= W_SDR;
            src_q    <= SRC_ZERO;
            dummy_q  <= 1'b0;
            id_idx_q <= 2'd0;
            bit_q    <= 3'd0;
            tx_q     <= 8'h00;
            qdo_q    <= 4'h0;
            oe_q     <= 4'h0;
            fa_q     <= 24'd0;
            rd_q     <= 1'b0;
            pend_q   <= 1'b0;
            stale_q  <= 1'b0;
            want_q   <= 1'b0;
            bvld_q   <= 1'b0;
            buf_q    <= 8'h00;
            unr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            width_q  <= width_d;
            src_q    <= src_d;
            dummy_q  <= dummy_d;
            id_idx_q <= id_idx_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            qdo_q    <= qdo_d;
            oe_q     <= oe_d;
            fa_q     <= fa_d;
            rd_q     <= rd_d;
            pend_q   <= pend_d;
            stale_q  <= stale_d;
            want_q   <= want_d;
            bvld_q   <= bvld_d;
            buf_q    <= buf_d;
            unr_q    <= unr_d;
        end
    end

    assign bus.qdo      = qdo_q & PIN_MASK;
    assign bus.oe       = oe_q & PIN_MASK;
    assign bus.mem_addr = fa_q;
    assign bus.mem_rd   = rd_q;
    assign busy         = (state_q != ST_IDLE);
    assign underrun     = unr_q;

endmodule

// File: tb/tb_sflash_target.sv
// Directed bench for sflash_target: SPI master tasks plus a byte memory.
// Memory byte at address a is a[7:0] + a[23:16] + 0x31.
module tb_sflash_target;

    localparam int H = 60;

    logic clk;
    logic arstn;
    logic busy;
    logic underrun;

    sflash_target_if u_if ();

    sflash_target u_dut (
        .clk      (clk),
        .arstn    (arstn),
        .bus      (u_if.slave),
        .busy     (busy),
        .underrun (underrun)
    );

    int          n_run;
    int          n_fail;
    int          rd_cnt;
    logic        rd_pend;
    logic [23:0] rd_addr;
    logic        hold_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] + a[23:16] + 8'h31;
    endfunction

    // Memory: acks one clock after a request unless held
    initial begin
        forever begin
            @(posedge clk);
            #1;
            u_if.mem_ack = 1'b0;
            if (rd_pend && !hold_ack) begin
                u_if.mem_ack  = 1'b1;
                u_if.mem_data = mem_byte(rd_addr);
                rd_pend       = 1'b0;
            end
            if (u_if.mem_rd === 1'b1) begin
                rd_pend = 1'b1;
                rd_addr = u_if.mem_addr;
                rd_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic spi_clk(input logic [3:0] dout,
                           output logic [3:0] din,
                           output logic [3:0] oe_s);
        u_if.sclk = 1'b0;
        u_if.qdi  = dout;
        #(H);
        din  = u_if.qdo;
        oe_s = u_if.oe;
        u_if.sclk = 1'b1;
        #(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] d;
        logic [3:0] o;
        for (int i = 7; i >= 0; i--) begin
            spi_clk({3'b000, b[i]}, d, o);
        end
    endtask

    task automatic recv_byte(input int w, input int rel_at,
                             output logic [7:0] b,
                             output logic [3:0] oe_s);
        logic [3:0] d;
        b = 8'h00;
        for (int i = 0; i < 8 / w; i++) begin
            if (i == rel_at) hold_ack = 1'b0;
            spi_clk(4'h0, d, oe_s);
            case (w)
                1:       b = {b[6:0], d[1]};
                2:       b = {b[5:0], d[1:0]};
                default: b = {b[3:0], d};
            endcase
        end
    endtask

    task automatic cs_lo();
        u_if.cs_n = 1'b0;
        #(H);
    endtask

    task automatic cs_hi();
        u_if.cs_n = 1'b1;
        #(H);
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        #23;
        n_run++;
        if (u_if.qdo !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_qdo: got %h want 0", u_if.qdo);
        end
        n_run++;
        if (u_if.oe !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_oe: got %h want 0", u_if.oe);
        end
        n_run++;
        if (u_if.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_rd: got %b want 0", u_if.mem_rd);
        end
        n_run++;
        if (u_if.mem_addr !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mem_addr: got %h want 0", u_if.mem_addr);
        end
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_run++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_underrun: got %b want 0", underrun);
        end
        #19;
        arstn = 1'b1;
        #(100);
    endtask

    task automatic test_rdid();
        logic [7:0] b;
        logic [3:0] o;
        logic [7:0] exp_id [5];
        exp_id = '{8'hC8, 8'h40, 8'h15, 8'h00, 8'h00};
        cs_lo();
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdid_busy: got %b want 1", busy);
        end
        send_byte(8'h9F);
        for (int i = 0; i < 5; i++) begin
            recv_byte(1, -1, b, o);
            n_run++;
            if (b !== exp_id[i]) begin
                n_fail++;
                $display("FAIL rdid_byte%0d: got %h want %h", i, b, exp_id[i]);
            end
            if (i == 0) begin
                n_run++;
                if (o !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL rdid_oe: got %b want 0010", o);
                end
            end
        end
        cs_hi();
        n_run++;
        if (u_if.oe !== 4'h0) begin
            n_fail++;
            $display("FAIL rdid_oe_off: got %b want 0000", u_if.oe);
        end
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdid_busy_off: got %b want 0", busy);
        end
    endtask

    task automatic test_read();
        logic [7:0] b;
        logic [3:0] o;
        int r0;
        r0 = rd_cnt;
        cs_lo();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h41) begin
            n_fail++;
            $display("FAIL read_b0: got %h want 41", b);
        end
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h42) begin
            n_fail++;
            $display("FAIL read_b1: got %h want 42", b);
        end
        cs_hi();
        n_run++;
        if (rd_cnt - r0 !== 3) begin
            n_fail++;
            $display("FAIL read_rd_count: got %0d want 3", rd_cnt - r0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic [3:0] d;
        logic [3:0] o;
        int r0;
        r0 = rd_cnt;
        cs_lo();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) spi_clk(4'h1, d, o);
        cs_hi();
        cs_lo();
        send_byte(8'h05);
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_status: got %h want 00", b);
        end
        n_run++;
        if (o !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_status_oe: got %b want 0010", o);
        end
        cs_hi();
        n_run++;
        if (rd_cnt !== r0) begin
            n_fail++;
            $display("FAIL abort_rd_count: got %0d want %0d", rd_cnt, r0);
        end
    endtask

    task automatic test_quad();
        logic [7:0] b0;
        logic [7:0] b1;
        logic [3:0] d;
        logic [3:0] o;
        logic [3:0] o0;
        logic       dmy_oe;
        int r0;
        r0 = rd_cnt;
        dmy_oe = 1'b0;
        cs_lo();
        send_byte(8'h6B);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        for (int i = 0; i < 8; i++) begin
            spi_clk(4'h0, d, o);
            if (o !== 4'h0) dmy_oe = 1'b1;
        end
        n_run++;
        if (dmy_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL quad_dummy_oe: got on want off");
        end
        recv_byte(4, -1, b0, o0);
        recv_byte(4, -1, b1, o);
        cs_hi();
`ifdef SFLASH_TARGET_QUAD_EN
        n_run++;
        if (b0 !== 8'h2F) begin
            n_fail++;
            $display("FAIL quad_b0: got %h want 2f", b0);
        end
        n_run++;
        if (b1 !== 8'h31) begin
            n_fail++;
            $display("FAIL quad_b1: got %h want 31", b1);
        end
        n_run++;
        if (o0 !== 4'b1111) begin
            n_fail++;
            $display("FAIL quad_oe: got %b want 1111", o0);
        end
        n_run++;
        if (rd_cnt - r0 !== 3) begin
            n_fail++;
            $display("FAIL quad_rd_count: got %0d want 3", rd_cnt - r0);
        end
`else
        n_run++;
        if (o0 !== 4'b0000 || o !== 4'b0000) begin
            n_fail++;
            $display("FAIL quad_off_oe: got %b/%b want 0000", o0, o);
        end
        n_run++;
        if (rd_cnt !== r0) begin
            n_fail++;
            $display("FAIL quad_off_rd_count: got %0d want %0d", rd_cnt, r0);
        end
`endif
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        logic [3:0] d;
        logic [3:0] o;
        hold_ack = 1'b1;
        cs_lo();
        send_byte(8'h0B);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h23);
        for (int i = 0; i < 8; i++) spi_clk(4'h0, d, o);
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'hFF) begin
            n_fail++;
            $display("FAIL under_b0: got %h want ff", b);
        end
        recv_byte(1, 2, b, o);
        n_run++;
        if (b !== 8'hFF) begin
            n_fail++;
            $display("FAIL under_b1: got %h want ff", b);
        end
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h54) begin
            n_fail++;
            $display("FAIL under_b2: got %h want 54", b);
        end
        n_run++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL under_flag: got %b want 1", underrun);
        end
        cs_hi();
        n_run++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL under_sticky: got %b want 1", underrun);
        end
        cs_lo();
        n_run++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL under_clear: got %b want 0", underrun);
        end
        cs_hi();
    endtask

    task automatic test_arst_mid();
        logic [7:0] b;
        logic [3:0] d;
        logic [3:0] o;
        logic       bad;
        cs_lo();
        send_byte(8'h3B);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        for (int i = 0; i < 8; i++) spi_clk(4'h0, d, o);
        recv_byte(2, -1, b, o);
        n_run++;
        if (b !== 8'h71) begin
            n_fail++;
            $display("FAIL dual_b0: got %h want 71", b);
        end
        u_if.sclk = 1'b0;
        #(H);
        n_run++;
        if (u_if.oe !== 4'b0011) begin
            n_fail++;
            $display("FAIL dual_oe: got %b want 0011", u_if.oe);
        end
        arstn = 1'b0;
        #1;
        n_run++;
        if (u_if.oe !== 4'h0 || u_if.qdo !== 4'h0) begin
            n_fail++;
            $display("FAIL arst_async: oe %b qdo %b want 0", u_if.oe, u_if.qdo);
        end
        #9;
        arstn = 1'b1;
        #(H - 10);
        u_if.sclk = 1'b1;
        #(H);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            spi_clk(4'h0, d, o);
            if (o !== 4'h0 || busy !== 1'b0) bad = 1'b1;
        end
        n_run++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ignore_frame: got active want idle");
        end
        cs_hi();
        cs_lo();
        send_byte(8'h03);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h05);
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h40) begin
            n_fail++;
            $display("FAIL arst_read_b0: got %h want 40", b);
        end
        recv_byte(1, -1, b, o);
        n_run++;
        if (b !== 8'h41) begin
            n_fail++;
            $display("FAIL arst_read_b1: got %h want 41", b);
        end
        cs_hi();
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        rd_cnt      = 0;
        rd_pend     = 1'b0;
        rd_addr     = 24'h0;
        hold_ack    = 1'b0;
        u_if.sclk     = 1'b1;
        u_if.cs_n     = 1'b1;
        u_if.qdi      = 4'h0;
        u_if.mem_ack  = 1'b0;
        u_if.mem_data = 8'h00;
        test_reset();
        test_rdid();
        test_read();
        test_abort();
        test_quad();
        test_underrun();
        test_arst_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
